instr_fetch: RTL

Instruction fetch stage and IF/ID pipeline register for the 16-bit ThinPad CPU. Owns the PC, issues word reads to the shared instruction/data RAM, and delivers one instruction per cycle, with its next-PC, to the decode stage's `instr` input. Handles the shared-RAM structural hazard, pipeline stalls (one-entry skid buffer), and branch/jump redirects (flush).

---
 rtl/instr_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit ThinPad CPU.
// Owns the PC and issues word reads to the shared RAM. It delivers one
// instruction per cycle, together with its PC+1, to the decode stage.
// A one-entry skid buffer catches a read that returns while decode is stalled.
// A redirect squashes everything in flight and reloads the PC.
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_busy,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] ram_rdata,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  output logic [15:0] id_instr,
  output logic [15:0] id_npc,
  output logic        id_valid
);

  logic [15:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflightPc_q, inflightPc_d;
  logic        bufValid_q, bufValid_d;
  logic [15:0] bufInstr_q, bufInstr_d;
  logic [15:0] bufPc_q, bufPc_d;
  logic [15:0] idInstr_q, idInstr_d;
  logic [15:0] idNpc_q, idNpc_d;
  logic        idValid_q, idValid_d;

  // A new read is issued only when nothing else needs the RAM or the IF/ID slot.
  // A full skid buffer also blocks issue, so at most one word is ever outstanding.
  always_comb begin
    fetch_req  = !rst && !stall && !mem_busy && !redirect && !bufValid_q;
    fetch_addr = pc_q;
  end

  // Next-state selection: redirect squashes, stall parks returning data, else IF/ID advances
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    inflightPc_d = inflightPc_q;
    bufValid_d   = bufValid_q;
    bufInstr_d   = bufInstr_q;
    bufPc_d      = bufPc_q;
    idInstr_d    = idInstr_q;
    idNpc_d      = idNpc_q;
    idValid_d    = idValid_q;

    if (redirect) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      bufValid_d = 1'b0;
      idInstr_d  = NOP_INSTR;
      idValid_d  = 1'b0;
    end else begin
      if (stall) begin
        if (inflight_q) begin
          bufInstr_d = ram_rdata;
          bufPc_d    = inflightPc_q;
          bufValid_d = 1'b1;
        end
      end else if (bufValid_q) begin
        idInstr_d  = bufInstr_q;
        idNpc_d    = bufPc_q + 16'd1;
        idValid_d  = 1'b1;
        bufValid_d = 1'b0;
      end else if (inflight_q) begin
        idInstr_d = ram_rdata;
        idNpc_d   = inflightPc_q + 16'd1;
        idValid_d = 1'b1;
      end else begin
        idInstr_d = NOP_INSTR;
        idValid_d = 1'b0;
      end

      inflight_d = fetch_req;
      if (fetch_req) begin
        inflightPc_d = pc_q;
        pc_d         = pc_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset back to an empty pipeline at RESET_PC
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= 16'h0000;
      bufValid_q   <= 1'b0;
      bufInstr_q   <= 16'h0000;
      bufPc_q      <= 16'h0000;
      idInstr_q    <= NOP_INSTR;
      idNpc_q      <= 16'h0000;
      idValid_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      bufValid_q   <= bufValid_d;
      bufInstr_q   <= bufInstr_d;
      bufPc_q      <= bufPc_d;
      idInstr_q    <= idInstr_d;
      idNpc_q      <= idNpc_d;
      idValid_q    <= idValid_d;
    end
  end

  assign id_instr = idInstr_q;
  assign id_npc   = idNpc_q;
  assign id_valid = idValid_q;

endmodule
